// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and sizing helper for the segment scan controller.
package seg_pkg;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam int NUM_DIGITS_DEF = 4;
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction
endpackage

// File: rtl/seven_segment.sv
// seven_segment: hex nibble to active-low segment pattern, g..a = bit 6..0.
module seven_segment (
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    localparam logic [6:0] LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    assign seg = LUT[hex];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scanner with frame-aligned double-buffered updates.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int DIV        = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [6:0]              seg,
    output logic                    frame_done,
    output logic                    upd_pending
);
    localparam int CW = cnt_width(DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] act_data, pend_data;
    logic [NUM_DIGITS-1:0]   act_blank, pend_blank;
    logic                    tick, wrap, dark;
    logic [3:0]              nib;
    logic [6:0]              dec_seg;
    assign tick = enable && cnt == CW'(DIV - 1);
    assign wrap = tick && idx == IW'(NUM_DIGITS - 1);
    assign nib  = act_data[4*idx +: 4];
    assign dark = !enable || act_blank[idx];
    seven_segment u_dec (.hex(nib), .seg(dec_seg));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= (tick || !enable) ? '0 : cnt + 1'b1;
            if (tick)
                idx <= wrap ? '0 : idx + 1'b1;
        end
    end
    // Active frame only changes at the wrap; a load on the wrap bypasses the pending buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_data    <= '0;
            act_blank   <= '0;
            pend_data   <= '0;
            pend_blank  <= '0;
            upd_pending <= 1'b0;
        end else if (wrap) begin
            upd_pending <= 1'b0;
            if (load) begin
                act_data  <= data;
                act_blank <= blank_mask;
            end else if (upd_pending) begin
                act_data  <= pend_data;
                act_blank <= pend_blank;
            end
        end else if (load) begin
            pend_data   <= data;
            pend_blank  <= blank_mask;
            upd_pending <= 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_sel  <= '1;
            seg        <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            digit_sel  <= dark ? '1 : ~(NUM_DIGITS'(1) << idx);
            seg        <= dark ? SEG_OFF : dec_seg;
            frame_done <= wrap;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed table, corner sequences and random run against a reference model.
module tb_seg_scan_ctrl;
    localparam int N = 4;
    localparam int DIV = 4;
    // conventional active-high patterns; the display uses their complement
    localparam logic [6:0] HI [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic clk = 0, rst_n = 0, enable = 0, load = 0;
    logic [4*N-1:0] data = '0;
    logic [N-1:0] blank_mask = '0;
    logic [N-1:0] digit_sel;
    logic [6:0] seg;
    logic frame_done, upd_pending;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.NUM_DIGITS(N), .DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .data(data),
        .blank_mask(blank_mask), .digit_sel(digit_sel), .seg(seg),
        .frame_done(frame_done), .upd_pending(upd_pending)
    );

    int total = 0, bad = 0;
    int m_idx, m_sub;
    logic [3:0] m_act [N];
    logic [3:0] m_pend [N];
    logic [N-1:0] m_blank, m_pblank, e_sel;
    logic m_upd, e_fd;
    logic [6:0] e_seg;

    typedef struct {
        logic en, ld;
        logic [15:0] data;
        logic [3:0] blank;
        int n;
        logic [3:0] sel;
        logic [6:0] seg;
        logic upd, fd;
    } vec_t;
    vec_t tbl [14];

    function automatic logic [6:0] dec(input logic [3:0] v);
        return ~HI[v];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_idx = 0; m_sub = 0;
        for (int i = 0; i < N; i++) begin m_act[i] = 0; m_pend[i] = 0; end
        m_blank = 0; m_pblank = 0; m_upd = 0;
        e_sel = '1; e_seg = 7'h7F; e_fd = 0;
    endtask

    // One clock of the display rules: show the current slot, then apply loads and advance time.
    task automatic model_step();
        bit tick, wrap;
        e_sel = '1;
        e_seg = 7'h7F;
        if (enable && !m_blank[m_idx]) begin
            e_sel[m_idx] = 1'b0;
            e_seg = dec(m_act[m_idx]);
        end
        tick = enable && m_sub == DIV - 1;
        wrap = tick && m_idx == N - 1;
        e_fd = wrap;
        if (wrap && load) begin
            for (int i = 0; i < N; i++) m_act[i] = data[4*i +: 4];
            m_blank = blank_mask;
            m_upd = 0;
        end else if (wrap && m_upd) begin
            for (int i = 0; i < N; i++) m_act[i] = m_pend[i];
            m_blank = m_pblank;
            m_upd = 0;
        end else if (load) begin
            for (int i = 0; i < N; i++) m_pend[i] = data[4*i +: 4];
            m_pblank = blank_mask;
            m_upd = 1;
        end
        m_sub = (!enable || tick) ? 0 : m_sub + 1;
        if (tick) m_idx = (m_idx + 1) % N;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("sel", 32'(digit_sel), 32'(e_sel));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        chk("upd_pending", 32'(upd_pending), 32'(m_upd));
    endtask

    initial begin
        int k;
        model_reset();
        tbl[0]  = '{1, 0, 16'h0000, 4'b0000, 1, 4'hE, 7'h40, 0, 0};
        tbl[1]  = '{1, 0, 16'h0000, 4'b0000, 4, 4'hD, 7'h40, 0, 0};
        tbl[2]  = '{1, 1, 16'h1234, 4'b0000, 1, 4'hD, 7'h40, 1, 0};
        tbl[3]  = '{1, 0, 16'h1234, 4'b0000, 4, 4'hB, 7'h40, 1, 0};
        tbl[4]  = '{1, 0, 16'h1234, 4'b0000, 4, 4'h7, 7'h40, 1, 0};
        tbl[5]  = '{1, 0, 16'h1234, 4'b0000, 2, 4'h7, 7'h40, 0, 1};
        tbl[6]  = '{1, 0, 16'h1234, 4'b0000, 1, 4'hE, 7'h19, 0, 0};
        tbl[7]  = '{1, 0, 16'h1234, 4'b0000, 4, 4'hD, 7'h30, 0, 0};
        tbl[8]  = '{1, 1, 16'h0000, 4'b0100, 1, 4'hD, 7'h30, 1, 0};
        tbl[9]  = '{1, 0, 16'h0000, 4'b0100, 10, 4'h7, 7'h79, 0, 1};
        tbl[10] = '{1, 0, 16'h0000, 4'b0100, 9, 4'hF, 7'h7F, 0, 0};
        tbl[11] = '{1, 0, 16'h0000, 4'b0100, 6, 4'h7, 7'h40, 0, 0};
        tbl[12] = '{1, 1, 16'h9876, 4'b0000, 1, 4'h7, 7'h40, 0, 1};
        tbl[13] = '{1, 0, 16'h9876, 4'b0000, 1, 4'hE, 7'h02, 0, 0};

        repeat (3) @(negedge clk);
        chk("rst_sel", 32'(digit_sel), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_upd", 32'(upd_pending), 32'h0);
        chk("rst_fd", 32'(frame_done), 32'h0);
        enable = 1;
        rst_n = 1;

        foreach (tbl[v]) begin
            enable = tbl[v].en; data = tbl[v].data; blank_mask = tbl[v].blank; load = tbl[v].ld;
            cyc();
            load = 0;
            repeat (tbl[v].n - 1) cyc();
            chk($sformatf("tbl%0d_sel", v), 32'(digit_sel), 32'(tbl[v].sel));
            chk($sformatf("tbl%0d_seg", v), 32'(seg), 32'(tbl[v].seg));
            chk($sformatf("tbl%0d_upd", v), 32'(upd_pending), 32'(tbl[v].upd));
            chk($sformatf("tbl%0d_fd", v), 32'(frame_done), 32'(tbl[v].fd));
        end

        // two loads in one frame: the last one wins at the wrap
        blank_mask = '0;
        data = 16'hAAAA; load = 1; cyc(); load = 0;
        cyc(); cyc();
        data = 16'h5555; load = 1; cyc(); load = 0;
        k = 0;
        while (!e_fd && k < 64) begin cyc(); k++; end
        chk("aa55_wrap_seen", 32'(k < 64), 32'h1);
        chk("aa55_upd_clear", 32'(upd_pending), 32'h0);
        for (int d = 0; d < N; d++) begin
            cyc();
            chk($sformatf("aa55_d%0d_seg", d), 32'(seg), 32'h12);
            repeat (DIV - 1) cyc();
        end

        // dark display still captures loads, then resumes from the held digit
        enable = 0; data = 16'h1111; load = 1; cyc(); load = 0;
        chk("dark_sel", 32'(digit_sel), 32'hF);
        chk("dark_seg", 32'(seg), 32'h7F);
        chk("dark_upd", 32'(upd_pending), 32'h1);
        repeat (5) cyc();
        enable = 1;
        repeat (2 * N * DIV) cyc();

        // reset mid-frame at digit 2 with a pending load
        k = 0;
        while (m_idx != 2 && k < 64) begin cyc(); k++; end
        chk("reach_idx2", 32'(k < 64), 32'h1);
        data = 16'hFFFF; load = 1; cyc(); load = 0;
        #2 rst_n = 0;
        #1;
        chk("arst_sel", 32'(digit_sel), 32'hF);
        chk("arst_seg", 32'(seg), 32'h7F);
        chk("arst_upd", 32'(upd_pending), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1; data = '0;
        cyc();
        chk("post_rst_sel", 32'(digit_sel), 32'hE);
        chk("post_rst_seg", 32'(seg), 32'h40);
        repeat (N * DIV) cyc();
        chk("post_rst_lost", 32'(seg), 32'h40);

        for (int r = 0; r < 3000; r++) begin
            enable = ($urandom_range(0, 9) != 0);
            load = ($urandom_range(0, 19) == 0);
            data = 16'($urandom);
            blank_mask = 4'($urandom);
            cyc();
            load = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
